// File: rtl/fop_pkg.sv
// Shared types and field helpers for the fop_mp accumulator core.
package fop_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUBI = 4'h3,
    OP_ANDI = 4'h4,
    OP_ST   = 4'h5,
    OP_LD   = 4'h6,
    OP_ADD  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_OUT  = 4'hA,
    OP_ADC  = 4'hB,
    OP_JC   = 4'hC,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_OUTW,
    S_HALT
  } state_e;

  function automatic int instr_w(input int dw);
    return dw + OPC_W;
  endfunction

  function automatic int opc_lsb(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/fop_imem.sv
// Instruction memory: one write port, registered read port, read-before-write.
module fop_imem #(
  parameter int AW = 4,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Both in one edge-triggered block: a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fop_mp.sv
// Multi-cycle accumulator core with imem, register file, branches, output handshake.
// Optional carry flag, ADC and JC enabled by defining FOP_CARRY_EN.
module fop_mp
  import fop_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int NREG   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [DATA_W+3:0]   prog_data,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   acc,
  output logic                zero,
  output logic                carry,
  output logic                halted
);

  localparam int IW = instr_w(DATA_W);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
`ifdef FOP_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  state_e                         r_state, w_state_n;
  logic [ADDR_W-1:0]              r_pc, w_pc_n;
  logic [DATA_W-1:0]              r_acc, w_acc_n;
  logic                           r_zero, w_zero_n;
  logic                           r_carry, w_carry_n;
  logic                           r_out_valid, w_out_valid_n;
  logic [DATA_W-1:0]              r_out_data, w_out_data_n;
  logic                           r_halted, w_halted_n;
  logic [NREG-1:0][DATA_W-1:0]    r_regs;
  logic                           w_reg_we, w_acc_wr;
  logic [IW-1:0]                  w_ir;
  logic [3:0]                     w_op;
  logic [DATA_W-1:0]              w_imm, w_rval;
  logic [ADDR_W-1:0]              w_tgt, w_pc1;
  logic [RW-1:0]                  w_ridx;
  logic [DATA_W:0]                w_sum;

  // imem read register doubles as the instruction register
  fop_imem #(.AW(ADDR_W), .DW(IW)) u_imem (
    .clk     (clk),
    .i_we    (prog_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_re    (enable && (r_state == S_FETCH)),
    .i_raddr (r_pc),
    .o_rdata (w_ir)
  );

  assign w_op   = w_ir[IW-1:opc_lsb(DATA_W)];
  assign w_imm  = w_ir[DATA_W-1:0];
  assign w_tgt  = w_imm[ADDR_W-1:0];
  assign w_ridx = w_imm[RW-1:0];
  assign w_rval = r_regs[w_ridx];
  assign w_pc1  = r_pc + ADDR_W'(1);

  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_acc_n       = r_acc;
    w_carry_n     = r_carry;
    w_out_valid_n = r_out_valid;
    w_out_data_n  = r_out_data;
    w_halted_n    = r_halted;
    w_reg_we      = 1'b0;
    w_acc_wr      = 1'b0;
    w_sum         = '0;
    case (r_state)
      S_FETCH: w_state_n = S_EXEC;
      S_EXEC: begin
        w_state_n = S_FETCH;
        w_pc_n    = w_pc1;
        case (w_op)
          OP_LDI:  begin w_acc_n = w_imm; w_acc_wr = 1'b1; end
          OP_ADDI: begin
            w_sum     = {1'b0, r_acc} + {1'b0, w_imm};
            w_acc_n   = w_sum[DATA_W-1:0];
            w_carry_n = CARRY_EN & w_sum[DATA_W];
            w_acc_wr  = 1'b1;
          end
          OP_SUBI: begin
            // top bit of the widened difference is the borrow
            w_sum     = {1'b0, r_acc} - {1'b0, w_imm};
            w_acc_n   = w_sum[DATA_W-1:0];
            w_carry_n = CARRY_EN & w_sum[DATA_W];
            w_acc_wr  = 1'b1;
          end
          OP_ANDI: begin w_acc_n = r_acc & w_imm; w_acc_wr = 1'b1; end
          OP_ST:   w_reg_we = 1'b1;
          OP_LD:   begin w_acc_n = w_rval; w_acc_wr = 1'b1; end
          OP_ADD: begin
            w_sum     = {1'b0, r_acc} + {1'b0, w_rval};
            w_acc_n   = w_sum[DATA_W-1:0];
            w_carry_n = CARRY_EN & w_sum[DATA_W];
            w_acc_wr  = 1'b1;
          end
          OP_JMP:  w_pc_n = w_tgt;
          OP_JZ:   if (r_zero) w_pc_n = w_tgt;
          OP_OUT: begin
            w_out_data_n  = r_acc;
            w_out_valid_n = 1'b1;
            w_state_n     = S_OUTW;
          end
          OP_ADC: if (CARRY_EN) begin
            w_sum     = {1'b0, r_acc} + {1'b0, w_imm} + {{DATA_W{1'b0}}, r_carry};
            w_acc_n   = w_sum[DATA_W-1:0];
            w_carry_n = w_sum[DATA_W];
            w_acc_wr  = 1'b1;
          end
          OP_JC:   if (CARRY_EN && r_carry) w_pc_n = w_tgt;
          OP_HALT: begin w_state_n = S_HALT; w_halted_n = 1'b1; end
          default: ;
        endcase
      end
      S_OUTW: if (out_ready) begin
        w_out_valid_n = 1'b0;
        w_state_n     = S_FETCH;
      end
      default: ;
    endcase
    w_zero_n = w_acc_wr ? (w_acc_n == '0) : r_zero;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_acc       <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_halted    <= 1'b0;
      r_regs      <= '0;
    end else if (enable) begin
      r_state     <= w_state_n;
      r_pc        <= w_pc_n;
      r_acc       <= w_acc_n;
      r_zero      <= w_zero_n;
      r_carry     <= w_carry_n;
      r_out_valid <= w_out_valid_n;
      r_out_data  <= w_out_data_n;
      r_halted    <= w_halted_n;
      if (w_reg_we) r_regs[w_ridx] <= r_acc;
    end
  end

  assign pc        = r_pc;
  assign acc       = r_acc;
  assign zero      = r_zero;
  assign carry     = CARRY_EN & r_carry;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign halted    = r_halted;

endmodule

// File: tb/tb_fop_mp.sv
// Directed self-checking bench for fop_mp with default parameters.
module tb_fop_mp;

`ifdef FOP_CARRY_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic        clk, reset, enable, prog_we, out_ready;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic        out_valid, zero, carry, halted;
  logic [7:0]  out_data, acc;
  logic [3:0]  pc;

  int n_chk = 0;
  int n_pass = 0;

  fop_mp #(.DATA_W(8), .ADDR_W(4), .NREG(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .pc(pc), .acc(acc),
    .zero(zero), .carry(carry), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [3:0] a, input logic [3:0] op, input logic [7:0] imm);
    prog_addr = a;
    prog_data = {op, imm};
    prog_we   = 1'b1;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_basic();
    enable = 1'b0;
    ld(0, 4'h1, 8'd5);
    ld(1, 4'h2, 8'd3);
    ld(2, 4'hA, 8'd0);
    ld(3, 4'hF, 8'd0);
  endtask

  task automatic run_to_halt(input int budget, output int n);
    n = 0;
    enable = 1'b1;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    load_basic();
    reset = 1'b1;
    enable = 1'b1;
    tick();
    n_chk++; if ({pc, acc} !== 12'h000) $display("FAIL reset_pc_acc got %h want 000", {pc, acc}); else n_pass++;
    n_chk++; if ({zero, carry, halted} !== 3'b000) $display("FAIL reset_flags got %b want 000", {zero, carry, halted}); else n_pass++;
    n_chk++; if ({out_valid, out_data} !== 9'h000) $display("FAIL reset_out got %h want 000", {out_valid, out_data}); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int n, pulses;
    logic [7:0] seen;
    load_basic();
    out_ready = 1'b1;
    do_reset();
    enable = 1'b1;
    n = 0; pulses = 0; seen = 8'hxx;
    while (!halted && n < 30) begin
      tick();
      n++;
      if (out_valid) begin pulses++; seen = out_data; end
    end
    n_chk++; if (halted !== 1'b1) $display("FAIL basic_halted got %b want 1", halted); else n_pass++;
    n_chk++; if (n !== 9) $display("FAIL basic_cycles got %0d want 9", n); else n_pass++;
    n_chk++; if (pulses !== 1) $display("FAIL basic_pulses got %0d want 1", pulses); else n_pass++;
    n_chk++; if (seen !== 8'd8) $display("FAIL basic_out_data got %0d want 8", seen); else n_pass++;
    n_chk++; if (pc !== 4'd4) $display("FAIL basic_pc got %0d want 4", pc); else n_pass++;
    n_chk++; if (acc !== 8'd8) $display("FAIL basic_acc got %0d want 8", acc); else n_pass++;
    tick(); tick();
    n_chk++; if (pc !== 4'd4 || halted !== 1'b1) $display("FAIL basic_pc_frozen got pc=%0d h=%b want 4 1", pc, halted); else n_pass++;
  endtask

  task automatic test_backpressure();
    int n;
    bit bad;
    load_basic();
    out_ready = 1'b0;
    do_reset();
    enable = 1'b1;
    repeat (6) tick();
    n_chk++; if (out_valid !== 1'b1 || out_data !== 8'd8) $display("FAIL bp_rise got v=%b d=%0d want 1 8", out_valid, out_data); else n_pass++;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 8'd8 || pc !== 4'd3 || acc !== 8'd8) bad = 1'b1;
    end
    n_chk++; if (bad) $display("FAIL bp_hold got v=%b d=%0d pc=%0d acc=%0d want 1 8 3 8", out_valid, out_data, pc, acc); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_release got %b want 0", out_valid); else n_pass++;
    run_to_halt(10, n);
    n_chk++; if (halted !== 1'b1 || pc !== 4'd4 || n !== 2) $display("FAIL bp_halt got h=%b pc=%0d n=%0d want 1 4 2", halted, pc, n); else n_pass++;
  endtask

  task automatic test_branch();
    int n;
    enable = 1'b0;
    ld(0, 4'h1, 8'd1);
    ld(1, 4'h3, 8'd1);
    ld(2, 4'h9, 8'd5);
    ld(3, 4'h1, 8'h55);
    ld(4, 4'hF, 8'd0);
    ld(5, 4'hF, 8'd0);
    do_reset();
    enable = 1'b1;
    repeat (4) tick();
    n_chk++; if (acc !== 8'd0 || zero !== 1'b1) $display("FAIL br_subi got acc=%0d z=%b want 0 1", acc, zero); else n_pass++;
    n_chk++; if (carry !== 1'b0) $display("FAIL br_noborrow got %b want 0", carry); else n_pass++;
    repeat (2) tick();
    n_chk++; if (pc !== 4'd5) $display("FAIL br_jz_pc got %0d want 5", pc); else n_pass++;
    run_to_halt(10, n);
    n_chk++; if (pc !== 4'd6 || acc !== 8'd0) $display("FAIL br_end got pc=%0d acc=%0d want 6 0", pc, acc); else n_pass++;
  endtask

  task automatic test_overflow();
    enable = 1'b0;
    ld(0, 4'h1, 8'hFF);
    ld(1, 4'h2, 8'd1);
    ld(2, 4'hB, 8'd0);
    ld(3, 4'hF, 8'd0);
    do_reset();
    enable = 1'b1;
    repeat (4) tick();
    n_chk++; if (acc !== 8'd0 || zero !== 1'b1) $display("FAIL ov_wrap got acc=%0d z=%b want 0 1", acc, zero); else n_pass++;
    n_chk++; if (carry !== CE) $display("FAIL ov_carry got %b want %b", carry, CE); else n_pass++;
    repeat (2) tick();
    n_chk++; if (acc !== {7'd0, CE}) $display("FAIL ov_adc got %0d want %0d", acc, CE); else n_pass++;
    n_chk++; if (zero !== !CE) $display("FAIL ov_adc_zero got %b want %b", zero, !CE); else n_pass++;
  endtask

  task automatic test_regfile();
    int n;
    enable = 1'b0;
    ld(0, 4'h1, 8'd7);
    ld(1, 4'h5, 8'd6);
    ld(2, 4'h1, 8'd0);
    ld(3, 4'h6, 8'd2);
    ld(4, 4'h7, 8'd2);
    ld(5, 4'h4, 8'h0C);
    ld(6, 4'hF, 8'd0);
    do_reset();
    enable = 1'b1;
    repeat (8) tick();
    n_chk++; if (acc !== 8'd7 || zero !== 1'b0) $display("FAIL rf_ld got acc=%0d z=%b want 7 0", acc, zero); else n_pass++;
    repeat (2) tick();
    n_chk++; if (acc !== 8'd14) $display("FAIL rf_add got %0d want 14", acc); else n_pass++;
    run_to_halt(10, n);
    n_chk++; if (acc !== 8'd12 || pc !== 4'd7) $display("FAIL rf_andi got acc=%0d pc=%0d want 12 7", acc, pc); else n_pass++;
  endtask

  task automatic test_wrap();
    enable = 1'b0;
    for (int a = 0; a < 16; a++) ld(4'(a), 4'h0, 8'd0);
    do_reset();
    enable = 1'b1;
    repeat (30) tick();
    n_chk++; if (pc !== 4'd15) $display("FAIL wrap_pre got %0d want 15", pc); else n_pass++;
    repeat (2) tick();
    n_chk++; if (pc !== 4'd0 || acc !== 8'd0) $display("FAIL wrap_pc got pc=%0d acc=%0d want 0 0", pc, acc); else n_pass++;
  endtask

  task automatic test_enable_toggle();
    int n, rises;
    logic prev_v;
    load_basic();
    out_ready = 1'b1;
    do_reset();
    n = 0; rises = 0; prev_v = 1'b0;
    while (!halted && n < 40) begin
      enable = (n % 2 == 0);
      tick();
      n++;
      if (out_valid && !prev_v) rises++;
      prev_v = out_valid;
    end
    n_chk++; if (n !== 17) $display("FAIL en_cycles got %0d want 17", n); else n_pass++;
    n_chk++; if (rises !== 1 || out_data !== 8'd8) $display("FAIL en_out got rises=%0d d=%0d want 1 8", rises, out_data); else n_pass++;
    n_chk++; if (pc !== 4'd4 || acc !== 8'd8) $display("FAIL en_state got pc=%0d acc=%0d want 4 8", pc, acc); else n_pass++;
    enable = 1'b1;
  endtask

  task automatic test_reset_outw();
    int n;
    load_basic();
    out_ready = 1'b0;
    do_reset();
    enable = 1'b1;
    repeat (6) tick();
    n_chk++; if (out_valid !== 1'b1) $display("FAIL ro_valid got %b want 1", out_valid); else n_pass++;
    do_reset();
    n_chk++; if (out_valid !== 1'b0 || pc !== 4'd0 || acc !== 8'd0 || halted !== 1'b0) $display("FAIL ro_reset got v=%b pc=%0d acc=%0d h=%b want 0 0 0 0", out_valid, pc, acc, halted); else n_pass++;
    out_ready = 1'b1;
    run_to_halt(30, n);
    n_chk++; if (n !== 9 || pc !== 4'd4 || out_data !== 8'd8) $display("FAIL ro_rerun got n=%0d pc=%0d d=%0d want 9 4 8", n, pc, out_data); else n_pass++;
  endtask

  task automatic test_rbw();
    load_basic();
    do_reset();
    enable = 1'b1;
    prog_addr = 4'd0;
    prog_data = {4'h1, 8'd9};
    prog_we   = 1'b1;
    tick();
    prog_we   = 1'b0;
    tick();
    n_chk++; if (acc !== 8'd5) $display("FAIL rbw_old got %0d want 5", acc); else n_pass++;
    do_reset();
    repeat (2) tick();
    n_chk++; if (acc !== 8'd9) $display("FAIL rbw_new got %0d want 9", acc); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; prog_we = 1'b0; prog_addr = '0;
    prog_data = '0; out_ready = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_branch();
    test_overflow();
    test_regfile();
    test_wrap();
    test_enable_toggle();
    test_reset_outw();
    test_rbw();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
